pixel_stream_out: RTL

Output stage directly downstream of the pixel coordinate/colour generator. It takes the generator's per-pixel beat (colour plus `first`/`last_x` flags, qualified by `valid`) and buffers it in a small FIFO. It re-emits the beat as an AXI4-Stream video stream (`tuser` = start-of-frame, `tlast` = end-of-line) toward the video DMA/VDMA. It generates the `ready` backpressure the generator samples, and checks line and frame framing.

---
 rtl/video_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/pixel_stream_out.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared video definitions for the pixel generator and its output stage:
// default screen geometry, colour width and the per-pixel beat record that
// travels from the generator into the output FIFO.
// -----------------------------------------------------------------------------
package video_pkg;

   localparam int DEF_RBG_SIZE      = 24;
   localparam int DEF_SCREEN_WIDTH  = 640;
   localparam int DEF_SCREEN_HEIGHT = 480;

   // One pixel beat as produced by the generator.
   typedef struct packed {
      logic [DEF_RBG_SIZE-1:0] colour;
      logic                    first;   // pixel (0,0) of a frame
      logic                    last_x;  // last pixel of a line
   } pixel_beat_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is visible on rd_data whenever
// empty is low. A push on a full FIFO is accepted only when a pop happens in
// the same cycle; otherwise it is refused (wr_accept low). A pop on an empty
// FIFO is ignored.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   push         write request, wr_data   write data
//   wr_accept    push was taken this cycle
//   pop          read request (ignored when empty)
//   rd_data      head entry (show-ahead)
//   empty, full  status, count  current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_accept,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_ok;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign pop_ok    = pop && !empty;
   assign wr_accept = push && (!full || pop_ok);
   assign rd_data   = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)    rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_accept, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; count/pointers define what is valid, and the top gates outputs.
   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/pixel_stream_out.sv
// -----------------------------------------------------------------------------
// pixel_stream_out
// Output stage behind the pixel generator. Buffers generator beats in a small
// FIFO and re-emits them as an AXI4-Stream video stream (tuser = start of
// frame, tlast = end of line). Produces the ready backpressure the generator
// samples and checks line/frame framing on every accepted beat.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_colour/in_first/in_last_x    generator beat, qualified by in_valid
//   in_ready                        generator may issue a beat next cycle
//   m_tdata/m_tuser/m_tlast/m_tvalid/m_tready   AXI4-Stream master
//   frame_count                     frames started (wraps)
//   line_err/frame_err/ovf_err      sticky framing / overflow flags
//
// RBG_SIZE must equal the package colour width because the beat struct is
// shared with the generator.
// -----------------------------------------------------------------------------
module pixel_stream_out
   import video_pkg::*;
#(
   parameter int RBG_SIZE      = DEF_RBG_SIZE,
   parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter int DEPTH         = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [RBG_SIZE-1:0] in_colour,
   input  logic                in_first,
   input  logic                in_last_x,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [RBG_SIZE-1:0] m_tdata,
   output logic                m_tuser,
   output logic                m_tlast,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic [15:0]         frame_count,
   output logic                line_err,
   output logic                frame_err,
   output logic                ovf_err
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int X_W   = $clog2(SCREEN_WIDTH);
   localparam int Y_W   = $clog2(SCREEN_HEIGHT);
   localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_HEIGHT - 1);

   pixel_beat_t      wr_beat, rd_beat;
   logic             wr_accept, fifo_empty, fifo_full;
   logic [CNT_W-1:0] fifo_count;

   assign wr_beat = '{colour: in_colour, first: in_first, last_x: in_last_x};

   // in_valid is not gated by in_ready: the generator's valid lags its ready
   // sample by a cycle, so one beat may still arrive after ready falls.
   sync_fifo #(
      .WIDTH ($bits(pixel_beat_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid),
      .wr_data   (wr_beat),
      .wr_accept (wr_accept),
      .pop       (m_tready),
      .rd_data   (rd_beat),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // Ready leaves one free slot for the beat already in flight.
   assign in_ready = (fifo_count < CNT_W'(DEPTH - 1));

   // Payload is forced to zero while idle so unwritten storage never shows.
   assign m_tvalid = !fifo_empty;
   assign m_tdata  = m_tvalid ? rd_beat.colour : '0;
   assign m_tuser  = m_tvalid & rd_beat.first;
   assign m_tlast  = m_tvalid & rd_beat.last_x;

   // ---------------------------------------------------------------- framing
   logic [X_W-1:0] x_cnt_q, x_cnt_d, x_cur;
   logic [Y_W-1:0] y_cnt_q, y_cnt_d, y_cur;
   logic [15:0]    frame_count_q, frame_count_d;
   logic           line_err_q, line_err_d;
   logic           frame_err_q, frame_err_d;
   logic           ovf_err_q, ovf_err_d;
   logic           line_end;

   always_comb begin
      x_cnt_d       = x_cnt_q;
      y_cnt_d       = y_cnt_q;
      frame_count_d = frame_count_q;
      line_err_d    = line_err_q;
      frame_err_d   = frame_err_q;
      ovf_err_d     = ovf_err_q | (in_valid & ~wr_accept);
      x_cur         = x_cnt_q;
      y_cur         = y_cnt_q;
      line_end      = 1'b0;

      // Only accepted beats move the position; dropped beats are invisible.
      if (wr_accept) begin
         if (in_first) begin
            if (x_cnt_q != '0 || y_cnt_q != '0) frame_err_d = 1'b1;
            x_cur         = '0;
            y_cur         = '0;
            frame_count_d = frame_count_q + 16'd1;
         end
         // A misplaced or missing last_x is flagged, but the line still closes
         // so the checker stays aligned with whatever the generator does next.
         line_end = in_last_x || (x_cur == X_LAST);
         if (in_last_x != (x_cur == X_LAST)) line_err_d = 1'b1;
         if (line_end) begin
            x_cnt_d = '0;
            y_cnt_d = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
         end else begin
            x_cnt_d = x_cur + 1'b1;
            y_cnt_d = y_cur;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_cnt_q       <= '0;
         y_cnt_q       <= '0;
         frame_count_q <= '0;
         line_err_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         ovf_err_q     <= 1'b0;
      end else begin
         x_cnt_q       <= x_cnt_d;
         y_cnt_q       <= y_cnt_d;
         frame_count_q <= frame_count_d;
         line_err_q    <= line_err_d;
         frame_err_q   <= frame_err_d;
         ovf_err_q     <= ovf_err_d;
      end
   end

   assign frame_count = frame_count_q;
   assign line_err    = line_err_q;
   assign frame_err   = frame_err_q;
   assign ovf_err     = ovf_err_q;

endmodule
